// File: rtl/audio_frame_scheduler.sv
// Codec DAC timing master: derives BCLK/DACLRCK from CLOCK_50 and hands one
// buffered stereo frame to the serializer at every frame boundary.
module audio_frame_scheduler #(
  parameter int CLK_DIV          = 16,
  parameter int BITS_PER_FRAME   = 64,
  parameter int FIFO_DEPTH       = 4,
  parameter int MUTE_ON_UNDERRUN = 0
) (
  input  logic                        CLOCK_50,
  input  logic                        RESET_N,
  input  logic                        ENABLE,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [15:0]                 in_left,
  input  logic [15:0]                 in_right,
  output logic                        BCLK,
  output logic                        DACLRCK,
  output logic [15:0]                 leftSample,
  output logic [15:0]                 rightSample,
  output logic                        frame_tick,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [7:0]                  underrun_count,
  input  logic                        clear_underrun
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(BITS_PER_FRAME);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_FRAME - 1);
  localparam logic [BW-1:0] BIT_HALF = BW'(BITS_PER_FRAME / 2);
  localparam logic [LW-1:0] DEPTH    = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;

  state_e                         state_q, state_d;
  logic [DW-1:0]                  div_q, div_d;
  logic [BW-1:0]                  bit_q, bit_d;
  logic                           bclk_q, bclk_d;
  logic                           lrck_q, lrck_d;
  logic [15:0]                    left_q, right_q;
  logic                           tick_q;
  logic [7:0]                     ucnt_q;
  logic [LW-1:0]                  level_q, level_d;
  logic [PW-1:0]                  wptr_q, rptr_q;
  logic                           rdy_q;
  logic [FIFO_DEPTH-1:0][31:0]    mem_q;

  logic div_tc, fall, wrap, start, stop_done, frame_bnd;
  logic push, pop, underrun;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bclk_d    = bclk_q;
    bit_d     = bit_q;
    lrck_d    = lrck_q;
    start     = 1'b0;
    stop_done = 1'b0;
    div_tc    = (state_q != IDLE) && (div_q == DIV_LAST);
    fall      = div_tc && bclk_q;
    wrap      = fall && (bit_q == BIT_LAST);
    case (state_q)
      IDLE: if (ENABLE) begin
        state_d = RUN;
        start   = 1'b1;
      end
      RUN:  if (!ENABLE) state_d = STOP;
      STOP: if (ENABLE) state_d = RUN;
            else if (wrap) begin
              state_d   = IDLE;
              stop_done = 1'b1;
            end
      default: state_d = IDLE;
    endcase
    // Leaving IDLE starts the left half immediately; finishing STOP parks all at 0.
    if (state_q == IDLE || stop_done) begin
      div_d  = '0;
      bclk_d = 1'b0;
      bit_d  = '0;
      lrck_d = start;
    end else begin
      div_d  = div_tc ? '0 : div_q + 1'b1;
      bclk_d = bclk_q ^ div_tc;
      if (fall) begin
        bit_d  = wrap ? '0 : bit_q + 1'b1;
        lrck_d = (bit_d < BIT_HALF);
      end
    end
    frame_bnd = start || (wrap && !stop_done);
  end

  assign push     = in_valid && rdy_q;
  assign pop      = frame_bnd && (level_q != '0);
  assign underrun = frame_bnd && (level_q == '0);
  assign level_d  = level_q + LW'(push) - LW'(pop);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      div_q   <= '0;
      bclk_q  <= 1'b0;
      bit_q   <= '0;
      lrck_q  <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
      tick_q  <= 1'b0;
      ucnt_q  <= '0;
      level_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bclk_q  <= bclk_d;
      bit_q   <= bit_d;
      lrck_q  <= lrck_d;
      tick_q  <= frame_bnd;
      level_q <= level_d;
      rdy_q   <= (level_d < DEPTH);
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop) begin
        rptr_q  <= rptr_q + 1'b1;
        left_q  <= mem_q[rptr_q][31:16];
        right_q <= mem_q[rptr_q][15:0];
      end else if (underrun && (MUTE_ON_UNDERRUN != 0)) begin
        left_q  <= '0;
        right_q <= '0;
      end
      if (clear_underrun)                   ucnt_q <= '0;
      else if (underrun && ucnt_q != 8'hFF) ucnt_q <= ucnt_q + 8'd1;
    end
  end

  // Sample storage carries no reset; validity is tracked by level/pointers.
  always_ff @(posedge CLOCK_50) begin
    if (push) mem_q[wptr_q] <= {in_left, in_right};
  end

  assign in_ready       = rdy_q;
  assign BCLK           = bclk_q;
  assign DACLRCK        = lrck_q;
  assign leftSample     = left_q;
  assign rightSample    = right_q;
  assign frame_tick     = tick_q;
  assign fifo_level     = level_q;
  assign underrun_count = ucnt_q;

endmodule

// File: tb/tb_audio_frame_scheduler.sv
// Bench: default-size instance for timing/sequence corners, small fast
// instance (muted underruns) for randomized traffic against a frame-level model.
module tb_audio_frame_scheduler;
  localparam int CD  = 2;
  localparam int BPF = 34;
  localparam int FD  = 4;
  localparam int FL  = 2 * CD * BPF;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_n;
  logic en, vld, clr, rdy, bclk, lrck, tick;
  logic [15:0] il, ir, L, R;
  logic [2:0]  lvl;
  logic [7:0]  ucnt;

  logic f_en, f_vld, f_clr, f_rdy, f_bclk, f_lrck, f_tick;
  logic [15:0] f_il, f_ir, f_L, f_R;
  logic [2:0]  f_lvl;
  logic [7:0]  f_ucnt;

  audio_frame_scheduler dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .ENABLE(en), .in_valid(vld), .in_ready(rdy),
    .in_left(il), .in_right(ir), .BCLK(bclk), .DACLRCK(lrck), .leftSample(L),
    .rightSample(R), .frame_tick(tick), .fifo_level(lvl), .underrun_count(ucnt),
    .clear_underrun(clr));

  audio_frame_scheduler #(.CLK_DIV(CD), .BITS_PER_FRAME(BPF), .FIFO_DEPTH(FD),
                          .MUTE_ON_UNDERRUN(1)) dut_f (
    .CLOCK_50(clk), .RESET_N(rst_n), .ENABLE(f_en), .in_valid(f_vld), .in_ready(f_rdy),
    .in_left(f_il), .in_right(f_ir), .BCLK(f_bclk), .DACLRCK(f_lrck), .leftSample(f_L),
    .rightSample(f_R), .frame_tick(f_tick), .fifo_level(f_lvl), .underrun_count(f_ucnt),
    .clear_underrun(f_clr));

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic en, v;
    logic [15:0] l, r;
    logic rdy;
    logic [2:0] lvl;
    logic tick;
    logic [15:0] eL, eR;
  } vec_t;
  vec_t tbl[9];

  // Frame-level model for the fast instance: time since last boundary plus a queue.
  bit          m_run = 0;
  int          m_t   = 0;
  logic [31:0] mq[$];
  logic [15:0] mL = 0, mR = 0;
  logic        mtick = 0;
  int          mu = 0;

  task automatic fstep(input logic e, input logic v, input logic [15:0] l,
                       input logic [15:0] r, input logic c);
    bit push, bnd;
    chk("f_left",     f_L,    mL);
    chk("f_right",    f_R,    mR);
    chk("f_tick",     f_tick, mtick);
    chk("f_level",    f_lvl,  mq.size());
    chk("f_in_ready", f_rdy,  mq.size() < FD);
    chk("f_underrun", f_ucnt, mu);
    chk("f_bclk",     f_bclk, m_run ? (m_t / CD) % 2 : 0);
    chk("f_daclrck",  f_lrck, m_run ? ((m_t / (2 * CD)) < BPF / 2) : 0);
    f_en = e; f_vld = v; f_il = l; f_ir = r; f_clr = c;
    push  = v && (mq.size() < FD);
    bnd   = e && (!m_run || m_t == FL - 1);
    mtick = bnd;
    if (bnd) begin
      if (mq.size() > 0) {mL, mR} = mq.pop_front();
      else begin
        if (mu < 255) mu++;
        mL = 0; mR = 0;
      end
    end
    if (push) mq.push_back({l, r});
    if (c) mu = 0;
    m_t   = bnd ? 0 : m_t + 1;
    m_run = m_run || e;
    @(negedge clk);
  endtask

  logic [15:0] dl[5] = '{16'h2222, 16'h3333, 16'h4444, 16'h4444, 16'h4444};
  logic [15:0] dr[5] = '{16'hE222, 16'hE333, 16'hE444, 16'hE444, 16'hE444};
  int          du[5] = '{0, 0, 0, 1, 2};

  initial begin
    int n, rises, lhi, gapbad, last_rise, falls, ticks, lastfall, t0, rate;
    logic prev_b;
    tbl[0] = '{1'b0, 1'b1, 16'h1234, 16'hABCD, 1'b1, 3'd1, 1'b0, 16'h0000, 16'h0000};
    tbl[1] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 3'd0, 1'b1, 16'h1234, 16'hABCD};
    tbl[2] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 3'd0, 1'b0, 16'h1234, 16'hABCD};
    tbl[3] = '{1'b0, 1'b1, 16'h1111, 16'hE111, 1'b1, 3'd1, 1'b0, 16'h1234, 16'hABCD};
    tbl[4] = '{1'b0, 1'b1, 16'h2222, 16'hE222, 1'b1, 3'd2, 1'b0, 16'h1234, 16'hABCD};
    tbl[5] = '{1'b0, 1'b1, 16'h3333, 16'hE333, 1'b1, 3'd3, 1'b0, 16'h1234, 16'hABCD};
    tbl[6] = '{1'b0, 1'b1, 16'h4444, 16'hE444, 1'b0, 3'd4, 1'b0, 16'h1234, 16'hABCD};
    tbl[7] = '{1'b0, 1'b1, 16'h5555, 16'hE555, 1'b0, 3'd4, 1'b0, 16'h1234, 16'hABCD};
    tbl[8] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 3'd4, 1'b0, 16'h1234, 16'hABCD};

    en = 0; vld = 0; clr = 0; il = 0; ir = 0;
    f_en = 0; f_vld = 0; f_clr = 0; f_il = 0; f_ir = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_bclk", bclk, 0); chk("rst_lrck", lrck, 0); chk("rst_left", L, 0);
    chk("rst_right", R, 0);   chk("rst_tick", tick, 0); chk("rst_ucnt", ucnt, 0);
    chk("rst_level", lvl, 0); chk("rst_ready", rdy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", rdy, 1);

    for (int i = 0; i < 9; i++) begin
      en = tbl[i].en; vld = tbl[i].v; il = tbl[i].l; ir = tbl[i].r;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), rdy,  tbl[i].rdy);
      chk($sformatf("tbl%0d_level", i), lvl,  tbl[i].lvl);
      chk($sformatf("tbl%0d_tick", i),  tick, tbl[i].tick);
      chk($sformatf("tbl%0d_left", i),  L,    tbl[i].eL);
      chk($sformatf("tbl%0d_right", i), R,    tbl[i].eR);
      chk($sformatf("tbl%0d_ucnt", i),  ucnt, 0);
    end
    vld = 0;

    // STOP runs out the current frame, then parks without popping.
    ticks = 0;
    repeat (2100) begin
      @(negedge clk);
      if (tick) ticks++;
    end
    chk("stop_ticks", ticks, 0); chk("stop_level", lvl, 4); chk("stop_left", L, 16'h1234);
    chk("stop_right", R, 16'hABCD); chk("stop_bclk", bclk, 0); chk("stop_lrck", lrck, 0);
    chk("stop_ucnt", ucnt, 0);

    en = 1;
    @(negedge clk);
    chk("run_tick", tick, 1); chk("run_left", L, 16'h1111); chk("run_right", R, 16'hE111);
    chk("run_level", lvl, 3); chk("ready_after_pop", rdy, 1);

    for (int k = 0; k < 5; k++) begin
      n = 0; rises = 0; lhi = 0; gapbad = 0; last_rise = -1; prev_b = bclk;
      do begin
        @(negedge clk);
        n++;
        if (lrck) lhi++;
        if (bclk && !prev_b) begin
          if (last_rise >= 0 && n - last_rise != 32) gapbad++;
          last_rise = n;
          rises++;
        end
        prev_b = bclk;
      end while (!tick && n < 3000);
      chk($sformatf("frame%0d_period", k), n, 2048);
      chk($sformatf("frame%0d_bclk_rises", k), rises, 64);
      chk($sformatf("frame%0d_bclk_gaps", k), gapbad, 0);
      chk($sformatf("frame%0d_lrck_high", k), lhi, 1024);
      chk($sformatf("frame%0d_left", k), L, dl[k]);
      chk($sformatf("frame%0d_right", k), R, dr[k]);
      chk($sformatf("frame%0d_ucnt", k), ucnt, du[k]);
    end
    t0 = cyc;

    clr = 1;
    @(negedge clk);
    clr = 0;
    chk("clear_ucnt", ucnt, 0);
    vld = 1; il = 16'h0C01; ir = 16'hF0C1;
    @(negedge clk);
    vld = 0;
    falls = 0; n = 0; prev_b = bclk;
    while (falls < 10 && n < 1000) begin
      @(negedge clk);
      n++;
      if (prev_b && !bclk) falls++;
      prev_b = bclk;
    end
    chk("bit10_reached", falls, 10);
    en = 0;
    rises = 0; ticks = 0; lastfall = 0;
    repeat (2200) begin
      @(negedge clk);
      if (tick) ticks++;
      if (bclk && !prev_b) rises++;
      if (prev_b && !bclk) lastfall = cyc;
      prev_b = bclk;
    end
    chk("drop_rises", rises, 54); chk("drop_ticks", ticks, 0);
    chk("drop_end_at_boundary", lastfall - t0, 2048);
    chk("drop_bclk", bclk, 0); chk("drop_lrck", lrck, 0); chk("drop_level", lvl, 1);
    chk("drop_left", L, 16'h4444); chk("drop_ucnt", ucnt, 0);

    en = 1;
    @(negedge clk);
    chk("restart_tick", tick, 1); chk("restart_left", L, 16'h0C01); chk("restart_level", lvl, 0);
    vld = 1; il = 16'h0D01; ir = 16'hF0D1;
    @(negedge clk);
    vld = 0;
    repeat (300) @(negedge clk);
    chk("pre_reset_level", lvl, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_bclk", bclk, 0); chk("async_lrck", lrck, 0); chk("async_left", L, 0);
    chk("async_right", R, 0); chk("async_tick", tick, 0); chk("async_ucnt", ucnt, 0);
    chk("async_level", lvl, 0); chk("async_ready", rdy, 0);
    en = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Randomized traffic on the fast instance.
    for (int c = 0; c < 200; c++)
      fstep(0, $urandom_range(0, 99) < 30, 16'($urandom), 16'($urandom), 0);
    for (int ph = 0; ph < 4; ph++) begin
      rate = (ph == 0) ? 10 : (ph == 1) ? 5 : (ph == 2) ? 40 : 0;
      for (int c = 0; c < 1000; c++)
        fstep(1, $urandom_range(0, 999) < rate, 16'($urandom), 16'($urandom),
              $urandom_range(0, 599) == 0);
    end
    repeat (260 * FL) fstep(1, 0, 0, 0, 0);
    chk("f_saturated", f_ucnt, 255);
    for (int i = 0; i < 200 && m_t != FL - 1; i++) fstep(1, 0, 0, 0, 0);
    fstep(1, 0, 0, 0, 1);
    chk("f_clear_wins", f_ucnt, 0);
    chk("f_clear_tick", f_tick, 1);
    fstep(1, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
